// File: rtl/mem_port_pkg.sv
// rtl/mem_port_pkg.sv - owner codes, FSM states and size constants for the memory port scheduler
package mem_port_pkg;
   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_F    = 2'd1;
   localparam logic [1:0] OWN_D    = 2'd2;
   localparam logic [1:0] OWN_X    = 2'd3;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   localparam logic [1:0] SEL_WORD = 2'b10;
endpackage

// File: rtl/mem_port_rr_pick.sv
// rtl/mem_port_rr_pick.sv - winner select: data first, fetch/aux round-robin
module mem_port_rr_pick
   import mem_port_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       f_cand,
   input  logic       d_cand,
   input  logic       x_cand,
   input  logic       grant,
   output logic [1:0] win
);
   // ptr_x=1 means aux is favoured on the next fetch/aux tie
   logic ptr_x;

   always_comb begin
      win = OWN_NONE;
      if (d_cand)
         win = OWN_D;
      else if (f_cand && x_cand)
         win = ptr_x ? OWN_X : OWN_F;
      else if (f_cand)
         win = OWN_F;
      else if (x_cand)
         win = OWN_X;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_x <= 1'b0;
      end else if (grant) begin
         if (win == OWN_F)
            ptr_x <= 1'b1;
         else if (win == OWN_X)
            ptr_x <= 1'b0;
      end
   end
endmodule

// File: rtl/mem_port_scheduler.sv
// rtl/mem_port_scheduler.sv - shares one memory port among fetch, data and aux masters
// Optional access timeout with err output: MEM_PORT_TIMEOUT_EN
module mem_port_scheduler
   import mem_port_pkg::*;
#(
   parameter int width   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             f_req,
   input  logic [width-1:0] f_addr,
   input  logic             flush,
   output logic             f_ack,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [1:0]       d_sel,
   input  logic [width-1:0] d_addr,
   input  logic [width-1:0] d_wdata,
   output logic             d_ack,
   input  logic             x_req,
   input  logic             x_we,
   input  logic [1:0]       x_sel,
   input  logic [width-1:0] x_addr,
   input  logic [width-1:0] x_wdata,
   output logic             x_ack,
   output logic [width-1:0] rdata,
   output logic [width-1:0] AddrOut,
   output logic [width-1:0] DataOut,
   input  logic [width-1:0] DataIn,
   output logic             we,
   output logic             re,
   output logic [1:0]       sel,
   input  logic             mdelay,
`ifdef MEM_PORT_TIMEOUT_EN
   output logic             err,
`endif
   output logic [1:0]       owner,
   output logic             busy
);
   state_t     state;
   logic       kill;
   logic       tmo;
   logic       done;
   logic       arb_en;
   logic       grant;
   logic [1:0] win;
   logic       f_cand, d_cand, x_cand;

   assign busy = (state == ST_ACCESS);

`ifdef MEM_PORT_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wait_cnt;

   assign tmo = busy && mdelay && (wait_cnt == CW'(TIMEOUT - 1));
   assign err = tmo;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wait_cnt <= '0;
      else if (done)
         wait_cnt <= '0;
      else if (busy && mdelay)
         wait_cnt <= wait_cnt + 1'b1;
   end
`else
   assign tmo = 1'b0;
`endif

   assign done   = busy && (!mdelay || tmo);
   // a timed-out access always drops to idle rather than chaining
   assign arb_en = !busy || (done && !tmo);

   // the completing owner's own request is not eligible in its completion cycle
   assign f_cand = f_req && !flush && !(done && owner == OWN_F);
   assign d_cand = d_req && !(done && owner == OWN_D);
   assign x_cand = x_req && !(done && owner == OWN_X);
   assign grant  = arb_en && (win != OWN_NONE);

   mem_port_rr_pick u_pick (
      .clk    (clk),
      .rst    (rst),
      .f_cand (f_cand),
      .d_cand (d_cand),
      .x_cand (x_cand),
      .grant  (grant),
      .win    (win)
   );

   assign f_ack = done && (owner == OWN_F) && !kill && !flush;
   assign d_ack = done && (owner == OWN_D);
   assign x_ack = done && (owner == OWN_X);
   assign rdata = DataIn;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         owner   <= OWN_NONE;
         AddrOut <= '0;
         DataOut <= '0;
         sel     <= '0;
         we      <= 1'b0;
         re      <= 1'b0;
         kill    <= 1'b0;
      end else begin
         if (done)
            kill <= 1'b0;
         else if (busy && owner == OWN_F && flush)
            kill <= 1'b1;

         if (grant) begin
            state <= ST_ACCESS;
            owner <= win;
            case (win)
               OWN_F: begin
                  AddrOut <= f_addr;
                  we      <= 1'b0;
                  re      <= 1'b1;
                  sel     <= SEL_WORD;
               end
               OWN_D: begin
                  AddrOut <= d_addr;
                  DataOut <= d_wdata;
                  we      <= d_we;
                  re      <= !d_we;
                  sel     <= d_sel;
               end
               OWN_X: begin
                  AddrOut <= x_addr;
                  DataOut <= x_wdata;
                  we      <= x_we;
                  re      <= !x_we;
                  sel     <= x_sel;
               end
               default: ;
            endcase
         end else if (done) begin
            state <= ST_IDLE;
            owner <= OWN_NONE;
            we    <= 1'b0;
            re    <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mem_port_scheduler.sv
// tb/tb_mem_port_scheduler.sv - directed self-checking bench for mem_port_scheduler
module tb_mem_port_scheduler;
   logic        clk = 1'b0;
   logic        rst;
   logic        f_req, flush, d_req, d_we, x_req, x_we, mdelay;
   logic [31:0] f_addr, d_addr, d_wdata, x_addr, x_wdata, DataIn;
   logic [1:0]  d_sel, x_sel;
   logic        f_ack, d_ack, x_ack, we, re, busy;
   logic [31:0] rdata, AddrOut, DataOut;
   logic [1:0]  sel, owner;
`ifdef MEM_PORT_TIMEOUT_EN
   logic        err;
`endif
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_scheduler #(.width(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .flush(flush), .f_ack(f_ack),
      .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
      .x_req(x_req), .x_we(x_we), .x_sel(x_sel), .x_addr(x_addr), .x_wdata(x_wdata), .x_ack(x_ack),
      .rdata(rdata), .AddrOut(AddrOut), .DataOut(DataOut), .DataIn(DataIn),
      .we(we), .re(re), .sel(sel), .mdelay(mdelay),
`ifdef MEM_PORT_TIMEOUT_EN
      .err(err),
`endif
      .owner(owner), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; f_req = 0; flush = 0; d_req = 0; d_we = 0; x_req = 0; x_we = 0; mdelay = 0;
      f_addr = 0; d_addr = 0; d_wdata = 0; x_addr = 0; x_wdata = 0; d_sel = 0; x_sel = 0;
      DataIn = 32'h1234_5678;
      #1;
      chk("rst_owner", owner, 0); chk("rst_re", re, 0); chk("rst_we", we, 0);
      chk("rst_addr", AddrOut, 0); chk("rst_dout", DataOut, 0); chk("rst_sel", sel, 0);
      chk("rst_busy", busy, 0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // contention: data, then fetch, then aux
      f_req = 1; f_addr = 32'h400;
      d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_sel = 2'b10;
      x_req = 1; x_we = 0; x_addr = 32'h500; x_sel = 2'b01;
      #1;
      chk("c0_idle", busy, 0);
      tick();
      chk("c1_owner", owner, 2); chk("c1_we", we, 1); chk("c1_re", re, 0);
      chk("c1_addr", AddrOut, 32'h200); chk("c1_dout", DataOut, 32'hDEADBEEF); chk("c1_dack", d_ack, 1);
      chk("c1_fack", f_ack, 0);
      d_req = 0;
      tick();
      chk("c2_owner", owner, 1); chk("c2_addr", AddrOut, 32'h400); chk("c2_re", re, 1);
      chk("c2_sel", sel, 2); chk("c2_fack", f_ack, 1); chk("c2_rdata", rdata, 32'h1234_5678);
      f_req = 0;
      tick();
      chk("c3_owner", owner, 3); chk("c3_addr", AddrOut, 32'h500); chk("c3_sel", sel, 1);
      chk("c3_xack", x_ack, 1);
      x_req = 0;
      tick();
      chk("c4_owner", owner, 0); chk("c4_re", re, 0);

      // single fetch
      f_req = 1; f_addr = 32'h100; DataIn = 32'hA5A5_0001;
      tick();
      chk("f1_re", re, 1); chk("f1_addr", AddrOut, 32'h100); chk("f1_fack", f_ack, 1);
      chk("f1_rdata", rdata, 32'hA5A5_0001);
      f_req = 0;
      tick();
      chk("f2_busy", busy, 0); chk("f2_re", re, 0);

      // wait states on a data read
      d_req = 1; d_we = 0; d_addr = 32'h600; d_sel = 2'b00; mdelay = 1; DataIn = 32'hCAFEF00D;
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("w_addr", AddrOut, 32'h600); chk("w_re", re, 1); chk("w_dack", d_ack, 0);
         tick();
      end
      mdelay = 0;
      #1;
      chk("w4_addr", AddrOut, 32'h600); chk("w4_dack", d_ack, 1); chk("w4_rdata", rdata, 32'hCAFEF00D);
      tick();
      d_req = 0;
      #1;
      chk("w5_busy", busy, 0);

      // flush kills an in-flight fetch
      f_req = 1; f_addr = 32'h700; mdelay = 1;
      tick();
      chk("k1_owner", owner, 1);
      flush = 1; f_req = 0;
      #1;
      chk("k1_fack", f_ack, 0);
      tick();
      flush = 0; mdelay = 0;
      #1;
      chk("k2_busy", busy, 1); chk("k2_fack", f_ack, 0);
      tick();
      chk("k3_busy", busy, 0);
      f_req = 1; f_addr = 32'h300; flush = 1;
      tick();
      chk("k4_blocked", owner, 0);
      flush = 0;
      tick();
      chk("k5_owner", owner, 1); chk("k5_addr", AddrOut, 32'h300); chk("k5_fack", f_ack, 1);
      f_req = 0;
      tick();

      // async reset in the middle of a stalled access
      d_req = 1; d_we = 1; d_addr = 32'h800; d_wdata = 32'h55; mdelay = 1;
      tick();
      chk("r1_we", we, 1); chk("r1_owner", owner, 2);
      rst = 1;
      #1;
      chk("r2_we", we, 0); chk("r2_re", re, 0); chk("r2_owner", owner, 0); chk("r2_dack", d_ack, 0);
      d_req = 0; mdelay = 0;
      tick();
      rst = 0;
      x_req = 1; x_we = 0; x_addr = 32'h900; x_sel = 2'b10;
      tick();
      chk("r3_owner", owner, 3); chk("r3_xack", x_ack, 1); chk("r3_addr", AddrOut, 32'h900);
      x_req = 0;
      tick();
      chk("r4_busy", busy, 0);

`ifdef MEM_PORT_TIMEOUT_EN
      d_req = 1; d_we = 0; d_addr = 32'hA00; mdelay = 1;
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("t_dack", d_ack, 0); chk("t_err", err, 0);
         tick();
      end
      chk("t4_dack", d_ack, 1); chk("t4_err", err, 1);
      d_req = 0;
      tick();
      chk("t5_busy", busy, 0);
      mdelay = 0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
